// File: rtl/if_types_pkg.sv
// Shared OBI interface types and helpers for the slave-side capture logic.
package if_types_pkg;

  // Default number of buffered A-channel requests.
  localparam int obi_a_fifo_depth_default = 4;

  // Widest data bus any OBI block in this codebase may use. Helpers are sized to
  // this and callers truncate to their own width.
  localparam int OBI_MAX_DATA_WIDTH = 1024;
  localparam int OBI_MAX_BE_WIDTH   = OBI_MAX_DATA_WIDTH / 8;

  // Expand a byte-enable vector into a bit mask: each enabled byte becomes 8'hFF.
  function automatic logic [OBI_MAX_DATA_WIDTH-1:0] be_mask(
    input logic [OBI_MAX_BE_WIDTH-1:0] be
  );
    logic [OBI_MAX_DATA_WIDTH-1:0] mask;
    for (int i = 0; i < OBI_MAX_BE_WIDTH; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/obi_fifo_mem.sv
// Register-array storage for the A-channel FIFO: one write port, one
// combinational read port.
module obi_fifo_mem #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Capture one entry at the write address.
  // NOTE: the data array has no reset; validity is tracked by the level counter,
  // so stale contents are never observed and reset fan-out stays small.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/obi_a_channel_fifo.sv
// OBI A-channel request buffer: accepts requests while space is available and
// presents them to the cache controller in strict arrival order.
module obi_a_channel_fifo
  import if_types_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = obi_a_fifo_depth_default,
  localparam int BE_WIDTH   = DATA_WIDTH / 8,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  obi_req_i,
  input  logic                  obi_we_i,
  input  logic [ADDR_WIDTH-1:0] obi_addr_i,
  input  logic [BE_WIDTH-1:0]   obi_be_i,
  input  logic [DATA_WIDTH-1:0] obi_wdata_i,
  output logic                  obi_gnt_o,
  input  logic                  internal_gnt_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_we_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [BE_WIDTH-1:0]   out_be_o,
  output logic [DATA_WIDTH-1:0] out_wdata_o,
  output logic                  out_misaligned_o,
  output logic [LVL_W-1:0]      level_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OFS_W   = $clog2(BE_WIDTH);
  localparam int ENTRY_W = 2 + ADDR_WIDTH + BE_WIDTH + DATA_WIDTH;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] wdata_masked;
  logic                  misaligned;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    rd_entry;

  logic                  head_misaligned;
  logic                  head_we;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [BE_WIDTH-1:0]   head_be;
  logic [DATA_WIDTH-1:0] head_wdata;

  // Grant only from free space; a full buffer does not look at a same-cycle pop.
  assign full      = (level == LVL_W'(DEPTH));
  assign obi_gnt_o = internal_gnt_i & ~full & ~flush_i;
  assign push      = obi_req_i & obi_gnt_o;
  assign pop       = out_valid_o & out_ready_i;

  assign out_valid_o = (level != '0);
  assign level_o     = level;

  // Reads carry no data; writes keep only the enabled bytes.
  assign wdata_masked = obi_we_i
                      ? (obi_wdata_i & DATA_WIDTH'(be_mask(OBI_MAX_BE_WIDTH'(obi_be_i))))
                      : '0;
  assign misaligned   = (obi_addr_i[OFS_W-1:0] != '0);
  assign wr_entry     = {misaligned, obi_we_i, obi_addr_i, obi_be_i, wdata_masked};

  obi_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign {head_misaligned, head_we, head_addr, head_be, head_wdata} = rd_entry;

  // Present the head entry; outputs read as zero whenever the buffer is empty.
  always_comb begin
    // NOTE: every output gets a default before the condition so no latch is inferred.
    out_we_o         = 1'b0;
    out_addr_o       = '0;
    out_be_o         = '0;
    out_wdata_o      = '0;
    out_misaligned_o = 1'b0;
    if (out_valid_o) begin
      out_we_o         = head_we;
      out_addr_o       = head_addr;
      out_be_o         = head_be;
      out_wdata_o      = head_wdata;
      out_misaligned_o = head_misaligned;
    end
  end

  // Pointer and occupancy bookkeeping; a flush overrides any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_a_channel_fifo.sv
// Self-checking bench for obi_a_channel_fifo: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_obi_a_channel_fifo;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int BW    = DW / 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          obi_req;
  logic          obi_we;
  logic [AW-1:0] obi_addr;
  logic [BW-1:0] obi_be;
  logic [DW-1:0] obi_wdata;
  logic          obi_gnt;
  logic          internal_gnt;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [BW-1:0] out_be;
  logic [DW-1:0] out_wdata;
  logic          out_misaligned;
  logic [LW-1:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic          mis;
  } req_t;

  req_t model_q[$];

  obi_a_channel_fifo #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .obi_req_i        (obi_req),
    .obi_we_i         (obi_we),
    .obi_addr_i       (obi_addr),
    .obi_be_i         (obi_be),
    .obi_wdata_i      (obi_wdata),
    .obi_gnt_o        (obi_gnt),
    .internal_gnt_i   (internal_gnt),
    .flush_i          (flush),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_we_o         (out_we),
    .out_addr_o       (out_addr),
    .out_be_o         (out_be),
    .out_wdata_o      (out_wdata),
    .out_misaligned_o (out_misaligned),
    .level_o          (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What the controller must see for a request, derived byte by byte.
  function automatic req_t expected_entry(input logic we, input logic [AW-1:0] addr,
                                          input logic [BW-1:0] be, input logic [DW-1:0] wd);
    req_t e;
    e.we    = we;
    e.addr  = addr;
    e.be    = be;
    e.wdata = '0;
    if (we) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) e.wdata[8*i +: 8] = wd[8*i +: 8];
      end
    end
    e.mis = ((addr % BW) != 0);
    return e;
  endfunction

  function automatic logic model_gnt();
    return internal_gnt && (model_q.size() < DEPTH) && !flush;
  endfunction

  // Reference model: a queue of accepted requests.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
    end else begin
      logic do_push;
      logic do_pop;
      do_push = obi_req && model_gnt();
      do_pop  = (model_q.size() != 0) && out_ready;
      if (flush) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(expected_entry(obi_we, obi_addr, obi_be, obi_wdata));
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("m_valid", 64'(out_valid), 64'(model_q.size() != 0));
      check("m_level", 64'(level), 64'(model_q.size()));
      check("m_gnt", 64'(obi_gnt), 64'(model_gnt()));
      if (model_q.size() != 0) begin
        check("m_we", 64'(out_we), 64'(model_q[0].we));
        check("m_addr", 64'(out_addr), 64'(model_q[0].addr));
        check("m_be", 64'(out_be), 64'(model_q[0].be));
        check("m_wdata", out_wdata, model_q[0].wdata);
        check("m_mis", 64'(out_misaligned), 64'(model_q[0].mis));
      end else begin
        check("m_empty_data", {out_wdata[31:0] | out_addr, 22'(0), out_we, out_misaligned,
                               out_be}, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
    obi_req   = req;
    obi_we    = we;
    obi_addr  = addr;
    obi_be    = be;
    obi_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    internal_gnt = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, '0);

    // Reset state.
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_gnt", 64'(obi_gnt), 64'd0);
    check("rst_data", out_wdata, 64'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    internal_gnt = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", 64'(obi_gnt), 64'd1);
    check("post_rst_level", 64'(level), 64'd0);

    // Single masked write.
    step();
    set_req(1'b1, 1'b1, 32'h10, 8'h0F, 64'hAABBCCDD_11223344);
    @(negedge clk);
    check("wr_gnt", 64'(obi_gnt), 64'd1);
    check("wr_valid_before", 64'(out_valid), 64'd0);
    step();
    set_req(1'b0, 1'b0, '0, '0, '0);
    out_ready = 1'b1;
    @(negedge clk);
    check("wr_valid", 64'(out_valid), 64'd1);
    check("wr_we", 64'(out_we), 64'd1);
    check("wr_addr", 64'(out_addr), 64'h10);
    check("wr_wdata", out_wdata, 64'h00000000_11223344);
    check("wr_mis", 64'(out_misaligned), 64'd0);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("wr_drained", 64'(level), 64'd0);

    // Fill to DEPTH, then a fifth request must see no grant.
    for (int i = 0; i < DEPTH; i++) begin
      step();
      set_req(1'b1, 1'(i), 32'h100 + 32'(16 * i), 8'hFF, 64'h0101010101010101 * 64'(i + 1));
    end
    step();
    set_req(1'b1, 1'b1, 32'h500, 8'hFF, 64'hDEAD);
    @(negedge clk);
    check("full_level", 64'(level), 64'd4);
    check("full_gnt", 64'(obi_gnt), 64'd0);
    step();
    set_req(1'b0, 1'b0, '0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("drain_addr", 64'(out_addr), 64'h100 + 64'(16 * i));
      check("drain_level", 64'(level), 64'(DEPTH - i));
      step();
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("drain_empty", 64'(level), 64'd0);

    // Push and pop every cycle: occupancy holds at one, pointers wrap.
    step();
    set_req(1'b1, 1'b1, 32'h200, 8'hFF, 64'h5555);
    for (int k = 1; k <= 20; k++) begin
      step();
      out_ready = 1'b1;
      set_req(1'b1, 1'b1, 32'h200 + 32'(8 * k), 8'hFF, 64'h0101010101010101 * 64'(k));
      @(negedge clk);
      check("stream_level", 64'(level), 64'd1);
    end
    step();
    set_req(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("stream_last_addr", 64'(out_addr), 64'h200 + 64'(8 * 20));
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("stream_empty", 64'(level), 64'd0);

    // Misaligned read.
    step();
    set_req(1'b1, 1'b0, 32'h13, 8'h03, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    set_req(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("rd_valid", 64'(out_valid), 64'd1);
    check("rd_mis", 64'(out_misaligned), 64'd1);
    check("rd_we", 64'(out_we), 64'd0);
    check("rd_wdata", out_wdata, 64'd0);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Flush with three entries buffered; the concurrent request is refused.
    for (int i = 0; i < 3; i++) begin
      step();
      set_req(1'b1, 1'b1, 32'h400 + 32'(8 * i), 8'hF0, 64'h1234_5678_9ABC_DEF0);
    end
    step();
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_level_before", 64'(level), 64'd3);
    check("flush_gnt", 64'(obi_gnt), 64'd0);
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("flush_level", 64'(level), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_gnt_back", 64'(obi_gnt), 64'd1);

    // Controller withholds acceptance while the request is held.
    step();
    internal_gnt = 1'b0;
    set_req(1'b1, 1'b1, 32'h600, 8'h01, 64'h77);
    @(negedge clk);
    check("ignt_gnt_low", 64'(obi_gnt), 64'd0);
    step();
    @(negedge clk);
    check("ignt_no_push", 64'(level), 64'd0);
    step();
    internal_gnt = 1'b1;
    @(negedge clk);
    check("ignt_gnt_high", 64'(obi_gnt), 64'd1);
    step();
    set_req(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("ignt_pushed", 64'(level), 64'd1);
    check("ignt_wdata", out_wdata, 64'h77);

    // Reset in the middle of traffic drops everything at once.
    step();
    set_req(1'b1, 1'b1, 32'h308, 8'hFF, 64'h99);
    step();
    set_req(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("pre_rst_level", 64'(level), 64'd2);
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_addr", 64'(out_addr), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_level", 64'(level), 64'd0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
